aes_key_sched_ctrl: RTL and testbench
=====================================

Name: aes_key_sched_ctrl

Overview:
Sequencer for the 4x4 byte AES round-key store (addressed state memory with write, read and an expand strobe). It loads a 128-bit cipher key byte-serially, then alternates between streaming each round key out and triggering key expansion. It sits between the key-input interface and the round-key consumer, and owns the store's cs/RW/address/operation pins and the round constant.

Parameters:
NUM_ROUNDS, 10, number of expansions after round key 0
RCON_INIT, 8'h01, round constant used for the first expansion

Ports:
CLK  in  1  clock, rising edge
RST  in  1  reset, asynchronous, active-high
start  in  1  begin a schedule run; sampled in IDLE only
key_in  in  8  cipher key byte, FIPS byte order
key_valid  in  1  key_in valid
key_ready  out  1  controller accepts key_in
rk_data  out  8  round-key byte
rk_valid  out  1  rk_data valid
rk_ready  in  1  consumer accepts rk_data
rk_round  out  4  round index of rk_data, 0..NUM_ROUNDS
rk_last  out  1  final byte of final round
busy  out  1  high in any state except IDLE
done  out  1  one-cycle pulse on run completion
mem_cs  out  1  store chip select
mem_rw  out  1  1 = read, 0 = write
mem_addr  out  4  {row[1:0], col[1:0]}
mem_wdata  out  8  store write data
mem_op  out  1  expand strobe (store replaces contents with next round key)
mem_rdata  in  8  store read data, registered, valid the cycle after the read
rcon  out  8  round constant; store XORs it into row 0 of the SubWord result

Behaviour:
- Reset (any time, including mid-run): state IDLE; all outputs 0 except rcon=RCON_INIT; round=0. Store contents untouched.
- Key byte n (0..15) maps to address {n[1:0], n[3:2]} (row = n mod 4, col = n div 4). The same order is used for LOAD and EMIT.
- IDLE: on start, go to LOAD with n=0. start is ignored while busy.
- LOAD: key_ready=1. Each key_valid&key_ready cycle writes key_in to the store (mem_cs=1, mem_rw=0) and increments n. Gaps are allowed. After n=15 is accepted, go to EMIT with n=0.
- EMIT, per byte:
  - RD: issue a read of addr(n) for one cycle.
  - HOLD: capture mem_rdata into rk_data and assert rk_valid. rk_data, rk_round and rk_last stay stable while rk_valid&!rk_ready.
  - On handshake: n++. After byte 15, go to DONE if round==NUM_ROUNDS, else REFRESH.
  - Minimum 2 cycles per byte.
- REFRESH: for addresses 3, 7, 11, 15 in that order, read then write the same byte back (8 cycles, no stalls). Writing column 3 reloads the store's RotWord/SubWord register, which updates only on column-3 writes. rcon is stable throughout.
- EXPAND: one cycle with mem_cs=1 and mem_op=1. Then round++ and rcon <= rcon[7] ? {rcon[6:0],0}^8'h1B : {rcon[6:0],0}. Go to EMIT with n=0.
- DONE: done=1 for one cycle; rcon reloads RCON_INIT; round=0; go to IDLE.
- rk_last = rk_valid & round==NUM_ROUNDS & n==15.
- mem_cs=0 in every cycle not listed above. mem_op is never asserted together with a read or write.
- key_ready=0 outside LOAD. rk_valid=0 outside EMIT HOLD.

Decomposition:
- Package aes_ctrl_pkg:
  - state enum {IDLE, LOAD, EMIT_RD, EMIT_HOLD, REFRESH, EXPAND, DONE}
  - RCON_POLY=8'h1B
  - COL3 refresh address list {4'h3, 4'h7, 4'hB, 4'hF}
  - key-index to address function
- One sub-module, aes_rcon_gen: holds rcon, with load_init and step inputs; xtime in GF(2^8).

Test Plan:
- FIPS-197 key 2b7e1516 28aed2a6 abf71588 09cf4f3c, rk_ready=1, with a behavioural store model -> round 1 = a0fafe17 88542cb1 23a33939 2a6c7605; round 10 = d014f9a8 c9ee2589 e13f0cc8 b6630ca6; rk_last on the byte a6; one done pulse.
- Monitor rcon during each EXPAND -> 01,02,04,08,10,20,40,80,1B,36; exactly 10 mem_op pulses; each preceded by exactly 8 refresh accesses to 3,7,11,15.
- Random rk_ready backpressure -> rk_data/rk_round stable while stalled; 176 bytes delivered, none duplicated or dropped.
- key_valid with random gaps -> exactly 16 writes to addresses 0,4,8,12,1,...,15; key_ready=0 in EMIT/REFRESH.
- RST asserted in EMIT of round 4 -> all outputs 0, rcon=01 immediately; a new start produces correct round 1 bytes.
- start pulsed while busy -> ignored; run completes with a single done pulse.

Source files
------------

// File: rtl/aes_ctrl_pkg.sv
// aes_ctrl_pkg: shared states, constants and helpers for the AES round-key store sequencer.
package aes_ctrl_pkg;
  typedef enum logic [2:0] {IDLE, LOAD, EMIT_RD, EMIT_HOLD, REFRESH, EXPAND, DONE} state_t;
  localparam logic [7:0] RCON_POLY = 8'h1B;
  localparam logic [3:0] COL3 [4] = '{4'h3, 4'h7, 4'hB, 4'hF};
  function automatic logic [3:0] key_addr(input logic [3:0] n);
    return {n[1:0], n[3:2]};
  endfunction
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? RCON_POLY : 8'h00);
  endfunction
endpackage

// File: rtl/aes_rcon_gen.sv
// aes_rcon_gen: round constant register, stepped by xtime in GF(2^8).
module aes_rcon_gen
  import aes_ctrl_pkg::*;
#(
  parameter logic [7:0] RCON_INIT = 8'h01
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       load_init,
  input  logic       step,
  output logic [7:0] rcon
);
  logic [7:0] rcon_q, rcon_d;
  always_comb rcon_d = load_init ? RCON_INIT : step ? xtime(rcon_q) : rcon_q;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) rcon_q <= RCON_INIT;
    else rcon_q <= rcon_d;
  end
  assign rcon = rcon_q;
endmodule

// File: rtl/aes_key_sched_ctrl.sv
// aes_key_sched_ctrl: loads a 128-bit key into the round-key store, then alternates
// streaming each round key out with a column-3 refresh and an expand strobe.
module aes_key_sched_ctrl
  import aes_ctrl_pkg::*;
#(
  parameter int unsigned NUM_ROUNDS = 10,
  parameter logic [7:0]  RCON_INIT  = 8'h01
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       start,
  input  logic [7:0] key_in,
  input  logic       key_valid,
  output logic       key_ready,
  output logic [7:0] rk_data,
  output logic       rk_valid,
  input  logic       rk_ready,
  output logic [3:0] rk_round,
  output logic       rk_last,
  output logic       busy,
  output logic       done,
  output logic       mem_cs,
  output logic       mem_rw,
  output logic [3:0] mem_addr,
  output logic [7:0] mem_wdata,
  output logic       mem_op,
  input  logic [7:0] mem_rdata,
  output logic [7:0] rcon
);
  localparam logic [3:0] LAST = 4'(NUM_ROUNDS);
  state_t     state_q, state_d;
  logic [3:0] n_q, n_d, round_q, round_d;
  logic [2:0] step_q, step_d;
  logic [7:0] rk_data_q;
  logic       fresh_q;
  logic       load_init, rcon_step, key_wr, emit_rd, refresh;
  always_comb begin
    state_d   = state_q;
    n_d       = n_q;
    round_d   = round_q;
    step_d    = step_q;
    load_init = 1'b0;
    rcon_step = 1'b0;
    case (state_q)
      IDLE: begin
        state_d = start ? LOAD : IDLE;
        n_d     = 4'd0;
      end
      LOAD: begin
        n_d     = key_valid ? n_q + 4'd1 : n_q;
        state_d = (key_valid && n_q == 4'hF) ? EMIT_RD : LOAD;
      end
      EMIT_RD: state_d = EMIT_HOLD;
      EMIT_HOLD: if (rk_ready) begin
        n_d     = n_q + 4'd1;
        step_d  = 3'd0;
        state_d = n_q != 4'hF ? EMIT_RD : round_q == LAST ? DONE : REFRESH;
      end
      REFRESH: begin
        step_d  = step_q + 3'd1;
        state_d = step_q == 3'd7 ? EXPAND : REFRESH;
      end
      EXPAND: begin
        rcon_step = 1'b1;
        round_d   = round_q + 4'd1;
        n_d       = 4'd0;
        state_d   = EMIT_RD;
      end
      DONE: begin
        load_init = 1'b1;
        round_d   = 4'd0;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q   <= IDLE;
      n_q       <= 4'd0;
      round_q   <= 4'd0;
      step_q    <= 3'd0;
      rk_data_q <= 8'h00;
      fresh_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      n_q       <= n_d;
      round_q   <= round_d;
      step_q    <= step_d;
      rk_data_q <= rk_data;
      fresh_q   <= state_q == EMIT_RD;
    end
  end
  // Read data arrives the cycle after EMIT_RD; later stall cycles replay the captured byte.
  assign rk_data   = fresh_q ? mem_rdata : rk_data_q;
  assign key_wr    = state_q == LOAD && key_valid;
  assign emit_rd   = state_q == EMIT_RD;
  assign refresh   = state_q == REFRESH;
  assign key_ready = state_q == LOAD;
  assign rk_valid  = state_q == EMIT_HOLD;
  assign rk_round  = round_q;
  assign rk_last   = rk_valid && round_q == LAST && n_q == 4'hF;
  assign busy      = state_q != IDLE;
  assign done      = state_q == DONE;
  assign mem_op    = state_q == EXPAND;
  assign mem_cs    = key_wr || emit_rd || refresh || mem_op;
  assign mem_rw    = emit_rd || (refresh && !step_q[0]);
  assign mem_addr  = (key_wr || emit_rd) ? key_addr(n_q) : refresh ? COL3[step_q[2:1]] : 4'h0;
  // Refresh writes echo the byte read one cycle earlier so the store reloads its SubWord register.
  assign mem_wdata = key_wr ? key_in : (refresh && step_q[0]) ? mem_rdata : 8'h00;
  aes_rcon_gen #(.RCON_INIT(RCON_INIT)) u_rcon (
    .clk      (CLK),
    .rst      (RST),
    .load_init(load_init),
    .step     (rcon_step),
    .rcon     (rcon)
  );
endmodule

// File: tb/tb_aes_key_sched_ctrl.sv
// tb_aes_key_sched_ctrl: random-stimulus bench with a behavioural round-key store and a FIPS-197 key expansion reference.
module tb_aes_key_sched_ctrl;
  logic       CLK = 1'b0, RST = 1'b1, start = 1'b0, key_valid = 1'b0, rk_ready = 1'b0;
  logic [7:0] key_in = 8'h00;
  logic       key_ready, rk_valid, rk_last, busy, done, mem_cs, mem_rw, mem_op;
  logic [7:0] rk_data, mem_wdata, rcon;
  logic [7:0] mem_rdata = 8'h00;
  logic [3:0] rk_round, mem_addr;
  int         n_chk = 0, n_bad = 0;
  logic [7:0] sbox_t [256];
  logic [7:0] st [16];
  logic [7:0] sw [4];
  logic [7:0] exp_b [176];
  logic [7:0] got_b [176];
  logic [7:0] exp_rcon [10];
  localparam logic [127:0] FIPS_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;

  aes_key_sched_ctrl dut (
    .CLK(CLK), .RST(RST), .start(start), .key_in(key_in), .key_valid(key_valid),
    .key_ready(key_ready), .rk_data(rk_data), .rk_valid(rk_valid), .rk_ready(rk_ready),
    .rk_round(rk_round), .rk_last(rk_last), .busy(busy), .done(done), .mem_cs(mem_cs),
    .mem_rw(mem_rw), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_op(mem_op),
    .mem_rdata(mem_rdata), .rcon(rcon)
  );

  always #5 CLK = ~CLK;

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00, x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p ^= x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1B : 8'h00);
    end
    return p;
  endfunction

  function automatic logic [7:0] sbox_of(input logic [7:0] x);
    logic [7:0] inv = 8'h00;
    logic [15:0] d;
    for (int y = 1; y < 256; y++) if (x != 0 && gmul(x, 8'(y)) == 8'h01) inv = 8'(y);
    d = {inv, inv};
    return inv ^ d[14:7] ^ d[13:6] ^ d[12:5] ^ d[11:4] ^ 8'h63;
  endfunction

  function automatic logic [7:0] tv(input int r);
    return sw[r] ^ (r == 0 ? rcon : 8'h00);
  endfunction

  // Store: 4x4 bytes, registered read, RotWord/SubWord register fed by column-3 writes.
  always @(posedge CLK) begin
    if (mem_cs && mem_op) begin
      for (int r = 0; r < 4; r++) begin
        st[r*4]   <= st[r*4] ^ tv(r);
        st[r*4+1] <= st[r*4+1] ^ st[r*4] ^ tv(r);
        st[r*4+2] <= st[r*4+2] ^ st[r*4+1] ^ st[r*4] ^ tv(r);
        st[r*4+3] <= st[r*4+3] ^ st[r*4+2] ^ st[r*4+1] ^ st[r*4] ^ tv(r);
      end
    end else if (mem_cs && mem_rw) mem_rdata <= st[mem_addr];
    else if (mem_cs) begin
      st[mem_addr] <= mem_wdata;
      if (mem_addr[1:0] == 2'd3) sw[2'(mem_addr[3:2] - 2'd1)] <= sbox_t[mem_wdata];
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic build_ref(input logic [127:0] key);
    logic [31:0] w [44];
    logic [31:0] t;
    logic [7:0]  rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = key[32*(3-i) +: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {sbox_t[t[23:16]], sbox_t[t[15:8]], sbox_t[t[7:0]], sbox_t[t[31:24]]} ^ {rc, 24'h0};
        exp_rcon[i/4-1] = rc;
        rc = {rc[6:0], 1'b0} ^ (rc[7] ? 8'h1B : 8'h00);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int b = 0; b < 176; b++) exp_b[b] = 8'(w[b/4] >> (8 * (3 - b % 4)));
  endtask

  task automatic check_reset_outs();
    check("rst_outs", {key_ready, rk_data, rk_valid, rk_round, rk_last, busy, done,
                       mem_cs, mem_rw, mem_addr, mem_wdata, mem_op}, 0);
    check("rst_rcon", rcon, 8'h01);
  endtask

  task automatic run(input logic [127:0] key, input int gap_pct, input int stall_pct, input int abort_round);
    int ki = 0, bi = 0, ops = 0, dones = 0;
    logic prev_stall = 1'b0, aborted = 1'b0;
    logic [12:0] prev_rk = '0;
    logic [4:0] acc [$];
    build_ref(key);
    @(posedge CLK); #1;
    start = 1'b1; key_valid = 1'b0; rk_ready = 1'b0;
    for (int cyc = 0; cyc < 6000; cyc++) begin
      @(negedge CLK);
      if (ki < 16) check("load_cs", mem_cs, key_valid && key_ready);
      else if (busy) check("kr_off", key_ready, 0);
      if (ki == 16 && mem_cs && !mem_op) acc.push_back({mem_rw, mem_addr});
      if (key_valid && key_ready) begin
        check("load_wr", {mem_rw, mem_op, mem_addr, mem_wdata},
              {2'b00, 4'((ki % 4) * 4 + ki / 4), key[8*(15-ki) +: 8]});
        ki++;
      end
      if (mem_op) begin
        check("op_cs", mem_cs, 1);
        check("ref_n", acc.size(), 8);
        for (int i = 0; i < acc.size() && i < 8; i++)
          check("ref_acc", acc[i], {1'(i % 2 == 0), 4'(3 + 4 * (i / 2))});
        check("rcon", rcon, ops < 10 ? exp_rcon[ops] : 8'h00);
        ops++;
        acc.delete();
      end
      if (prev_stall) begin
        check("stall_v", rk_valid, 1);
        check("stall_hold", {rk_data, rk_round, rk_last}, prev_rk);
      end
      if (rk_valid && rk_ready) begin
        if (bi >= 176) check("rk_extra", bi, 175);
        else begin
          check("rk_data", rk_data, exp_b[bi]);
          check("rk_round", rk_round, bi / 16);
          check("rk_last", rk_last, bi == 175);
          got_b[bi] = rk_data;
          bi++;
        end
        acc.delete();
      end
      prev_stall = rk_valid && !rk_ready;
      prev_rk = {rk_data, rk_round, rk_last};
      if (done) dones++;
      if (abort_round >= 0 && rk_valid && int'(rk_round) == abort_round) begin
        RST = 1'b1;
        #1;
        check_reset_outs();
        aborted = 1'b1;
        break;
      end
      if (dones > 0 && !busy) break;
      @(posedge CLK); #1;
      start     = busy && bi < 176 && $urandom_range(0, 7) == 0;
      key_valid = ki < 16 && $urandom_range(0, 99) >= gap_pct;
      key_in    = ki < 16 ? key[8*(15-ki) +: 8] : 8'($urandom);
      rk_ready  = $urandom_range(0, 99) >= stall_pct;
    end
    start = 1'b0; key_valid = 1'b0; rk_ready = 1'b0;
    if (aborted) begin
      repeat (2) @(negedge CLK);
      check("abort_idle", {busy, rcon}, {1'b0, 8'h01});
      RST = 1'b0;
    end else begin
      check("bytes", bi, 176);
      check("ops", ops, 10);
      check("dones", dones, 1);
      check("idle", busy, 0);
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) sbox_t[i] = sbox_of(8'(i));
    repeat (3) @(negedge CLK);
    check_reset_outs();
    RST = 1'b0;
    run(FIPS_KEY, 0, 0, -1);
    check("fips_r1_w0", {got_b[16], got_b[17], got_b[18], got_b[19]}, 32'ha0fafe17);
    check("fips_r10_w3", {got_b[172], got_b[173], got_b[174], got_b[175]}, 32'hb6630ca6);
    run({$urandom, $urandom, $urandom, $urandom}, 40, 40, -1);
    run(FIPS_KEY, 20, 30, 4);
    run(FIPS_KEY, 30, 50, -1);
    check("fips_r1_w1", {got_b[20], got_b[21], got_b[22], got_b[23]}, 32'h88542cb1);
    run({$urandom, $urandom, $urandom, $urandom}, 10, 20, -1);
    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end
endmodule
